// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared constants, ALU code classes and named op codes for the
//               ALU issue/writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    localparam int WIDTH  = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = $clog2(NREGS);

    // Upper two bits of the ALU code select the operation class
    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_SHIFT = 2'b10;
    localparam logic [1:0] CLS_CMP   = 2'b11;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_AND = 5'b01000;
    localparam logic [4:0] OP_LT  = 5'b11001;

    // Only arithmetic-class results may raise the sticky overflow flag
    function automatic logic is_arith(input logic [4:0] code);
        return code[4:3] == CLS_ARITH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NREGS x WIDTH register file, one synchronous write port,
//               three combinational read ports, asynchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rs1_addr,
    output logic [WIDTH-1:0] rs1_data,
    input  logic [AW-1:0]    rs2_addr,
    output logic [WIDTH-1:0] rs2_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] r_regs [NREGS];

    // Storage: cleared on reset, single write per edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Reads see the stored value; a same-cycle write shows up next cycle
    assign rs1_data = r_regs[rs1_addr];
    assign rs2_data = r_regs[rs2_addr];
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Two-stage issue/writeback wrapper around a combinational ALU.
//               Stage 1 registers operands and code into alu_a/alu_b/alu_code,
//               stage 2 writes alu_c back to the register file and updates a
//               sticky overflow flag. Direct register loads have priority
//               over issue.
//               Optional feature macro: ALU_ISSUE_FORWARD_EN - forwards the
//               in-flight ALU result to a dependent instruction instead of
//               stalling for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter  int WIDTH = alu_issue_pkg::WIDTH,
    parameter  int NREGS = alu_issue_pkg::NREGS,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [4:0]       instr_code,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_code,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_overflow,
    output logic             wb_valid,
    output logic [AW-1:0]    wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             ovf_sticky,
    input  logic             ovf_clr,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic             r_ex_valid;
    logic [AW-1:0]    r_ex_rd;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [4:0]       r_alu_code;
    logic             r_wb_valid;
    logic [AW-1:0]    r_wb_addr;
    logic [WIDTH-1:0] r_wb_data;
    logic             r_ovf_sticky;

    logic             w_issue;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [WIDTH-1:0] w_rf_rs1;
    logic [WIDTH-1:0] w_rf_rs2;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_rf_we;
    logic [AW-1:0]    w_rf_waddr;
    logic [WIDTH-1:0] w_rf_wdata;

`ifdef ALU_ISSUE_FORWARD_EN
    // Dependent operands come straight from the ALU output, so no stall
    assign w_fwd_a     = r_ex_valid && (instr_rs1 == r_ex_rd);
    assign w_fwd_b     = r_ex_valid && (instr_rs2 == r_ex_rd);
    assign instr_ready = !ld_valid;
`else
    logic w_raw_hazard;
    // Without forwarding, hold a dependent instruction until the writeback
    assign w_raw_hazard = r_ex_valid && ((instr_rs1 == r_ex_rd) || (instr_rs2 == r_ex_rd));
    assign w_fwd_a      = 1'b0;
    assign w_fwd_b      = 1'b0;
    assign instr_ready  = !ld_valid && !w_raw_hazard;
`endif

    assign w_issue  = instr_valid && instr_ready;
    // A load waits while a writeback owns the write port
    assign ld_ready = ld_valid && !r_ex_valid;

    assign w_op_a = w_fwd_a ? alu_c : w_rf_rs1;
    assign w_op_b = w_fwd_b ? alu_c : w_rf_rs2;

    // Writeback and load are mutually exclusive by construction of ld_ready
    assign w_rf_we    = r_ex_valid || ld_ready;
    assign w_rf_waddr = r_ex_valid ? r_ex_rd : ld_addr;
    assign w_rf_wdata = r_ex_valid ? alu_c   : ld_data;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (w_rf_we),
        .waddr    (w_rf_waddr),
        .wdata    (w_rf_wdata),
        .rs1_addr (instr_rs1),
        .rs1_data (w_rf_rs1),
        .rs2_addr (instr_rs2),
        .rs2_data (w_rf_rs2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Issue stage register: capture operands/code on accept, track occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_code <= '0;
        end else begin
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_rd    <= instr_rd;
                r_alu_a    <= w_op_a;
                r_alu_b    <= w_op_b;
                r_alu_code <= instr_code;
            end
        end
    end

    // Writeback report: one-cycle pulse with the address and value written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_wb_addr <= r_ex_rd;
                r_wb_data <= alu_c;
            end
        end
    end

    // Sticky overflow: arithmetic writebacks only, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end else if (r_ex_valid && is_arith(r_alu_code) && alu_overflow) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_code   = r_alu_code;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire
